// File: rtl/mmm_pkg.sv
// Shared types and default sizing for the matrix-multiply datapath.
package mmm_pkg;

   localparam int DEF_INW  = 12;
   localparam int DEF_M    = 7;
   localparam int DEF_N    = 9;
   localparam int DEF_MAXK = 8;

   localparam int A_DEPTH = DEF_M * DEF_MAXK;
   localparam int B_DEPTH = DEF_MAXK * DEF_N;

   typedef enum logic [1:0] {
      IDLE,
      LOAD_A,
      LOAD_B,
      FULL
   } ibuf_state_t;

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/sp_sram.sv
// Single-port memory: synchronous write, registered read.
// Latency 1 cycle read; no backpressure, write wins the shared address.
module sp_sram #(
   parameter int WIDTH = 12,
   parameter int SIZE  = 56,
   localparam int AW   = $clog2(SIZE)
) (
   input  logic             clk,
   input  logic             wr_en,
   input  logic [AW-1:0]    addr,
   input  logic [WIDTH-1:0] wr_data,
   output logic [WIDTH-1:0] rd_data
);

   logic [WIDTH-1:0] mem [SIZE];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[addr] <= wr_data;
      end
      rd_data <= mem[addr];
   end

endmodule

// File: rtl/matrix_input_buffer.sv
// Stores A (MxK) then B (KxN) from an AXI-Stream and serves them to the MAC controller.
// Read latency 1 cycle; TREADY drops while FULL until compute_finished releases the set.
module matrix_input_buffer
   import mmm_pkg::*;
#(
   parameter int INW  = DEF_INW,
   parameter int M    = DEF_M,
   parameter int N    = DEF_N,
   parameter int MAXK = DEF_MAXK,
   localparam int K_BITS = $clog2(MAXK + 1),
   localparam int A_AW   = $clog2(M * MAXK),
   localparam int B_AW   = $clog2(MAXK * N)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [INW-1:0]    AXIS_TDATA,
   input  logic              AXIS_TVALID,
   input  logic [K_BITS:0]   AXIS_TUSER,
   output logic              AXIS_TREADY,
   output logic              matrices_loaded,
   input  logic              compute_finished,
   output logic [K_BITS-1:0] K,
   input  logic [A_AW-1:0]   A_read_addr,
   output logic [INW-1:0]    A_data,
   input  logic [B_AW-1:0]   B_read_addr,
   output logic [INW-1:0]    B_data
);

   localparam int CW = $clog2(max2(M * MAXK, MAXK * N));

   ibuf_state_t       state_q, state_d;
   logic [CW-1:0]     wr_cnt_q, wr_cnt_d;
   logic [K_BITS-1:0] k_q, k_d;
   logic              xfer, a_we, b_we;
   logic [K_BITS-1:0] k_in;
   logic              new_a, a_last, b_last;
   logic [A_AW-1:0]   a_addr;
   logic [B_AW-1:0]   b_addr;

   assign k_in  = AXIS_TUSER[K_BITS:1];
   assign new_a = AXIS_TUSER[0];

   // Ready is a pure state decode so upstream never sees a path from its own TVALID.
   assign AXIS_TREADY     = !reset && (state_q != FULL);
   assign matrices_loaded = (state_q == FULL);
   assign xfer            = AXIS_TVALID && AXIS_TREADY;
   assign K               = k_q;

   assign a_last = (int'(wr_cnt_q) == M * int'(k_q) - 1);
   assign b_last = (int'(wr_cnt_q) == int'(k_q) * N - 1);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         wr_cnt_q <= '0;
         k_q      <= '0;
      end else begin
         state_q  <= state_d;
         wr_cnt_q <= wr_cnt_d;
         k_q      <= k_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      wr_cnt_d = wr_cnt_q;
      k_d      = k_q;
      a_we     = 1'b0;
      b_we     = 1'b0;
      case (state_q)
         IDLE: begin
            if (xfer) begin
               k_d      = k_in;
               wr_cnt_d = CW'(1);
               if (new_a) begin
                  a_we = 1'b1;
                  if (M * int'(k_in) == 1) begin
                     state_d  = LOAD_B;
                     wr_cnt_d = '0;
                  end else begin
                     state_d = LOAD_A;
                  end
               end else begin
                  // B-only set: A from the previous set is reused as-is.
                  b_we = 1'b1;
                  if (int'(k_in) * N == 1) begin
                     state_d  = FULL;
                     wr_cnt_d = '0;
                  end else begin
                     state_d = LOAD_B;
                  end
               end
            end
         end
         LOAD_A: begin
            if (xfer) begin
               a_we = 1'b1;
               if (a_last) begin
                  state_d  = LOAD_B;
                  wr_cnt_d = '0;
               end else begin
                  wr_cnt_d = wr_cnt_q + CW'(1);
               end
            end
         end
         LOAD_B: begin
            if (xfer) begin
               b_we = 1'b1;
               if (b_last) begin
                  state_d  = FULL;
                  wr_cnt_d = '0;
               end else begin
                  wr_cnt_d = wr_cnt_q + CW'(1);
               end
            end
         end
         FULL: begin
            if (compute_finished) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign a_addr = a_we ? wr_cnt_q[A_AW-1:0] : A_read_addr;
   assign b_addr = b_we ? wr_cnt_q[B_AW-1:0] : B_read_addr;

   sp_sram #(.WIDTH(INW), .SIZE(M * MAXK)) u_mem_a (
      .clk     (clk),
      .wr_en   (a_we),
      .addr    (a_addr),
      .wr_data (AXIS_TDATA),
      .rd_data (A_data)
   );

   sp_sram #(.WIDTH(INW), .SIZE(MAXK * N)) u_mem_b (
      .clk     (clk),
      .wr_en   (b_we),
      .addr    (b_addr),
      .wr_data (AXIS_TDATA),
      .rd_data (B_data)
   );

endmodule
